fetch_pc_gen: RTL and testbench

- Instruction-fetch front end, directly upstream of the instruction memory.
- Owns the PC, drives the memory read address, and absorbs the memory's fixed 1-cycle registered read latency.
- Presents {instruction, PC} to decode through a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_buf.sv | 44 ++++
 rtl/fetch_pc_gen.sv | 66 ++++++
 tb/tb_fetch_pc_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the buffered fetch entry type
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: DEPTH-entry FIFO of fetched {inst, pc} pairs with flush
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + AW'(1);
  endfunction
  assign do_pop = pop && count != '0;
  assign head = mem[rd_q];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      count <= '0;
    end else begin
      if (push) wr_q <= inc(wr_q);
      if (do_pop) rd_q <= inc(rd_q);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) mem <= '{default: '0};
    else if (push && !flush) mem[wr_q] <= push_data;
  end
  // a push into a full buffer is only legal when the head leaves in the same cycle
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: owns the PC, issues imem reads, tracks the in-flight word and feeds decode
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_fetch_misalign,
  output logic [31:0] o_misalign_pc
);
  localparam int CW = $clog2(DEPTH+1);
  logic [31:0] pc_q, inflight_pc_q;
  logic inflight_q, pop, push, issue, misalign;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head, ret;
  assign pop = o_inst_valid && i_inst_ready;
  assign push = inflight_q && !i_redirect_valid;
  // slots already promised: buffered entries plus the word still in the memory pipe
  assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = !i_redirect_valid && occ < (CW+1)'(DEPTH);
  assign misalign = i_redirect_valid && i_redirect_pc[1:0] != 2'b00;
  assign o_imem_addr = {pc_q[31:2], 2'b00};
  assign o_inst_valid = count != '0;
  assign o_inst = head.inst;
  assign o_inst_pc = head.pc;
  assign ret = '{inst: i_imem_data, pc: inflight_pc_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      o_fetch_misalign <= 1'b0;
      o_misalign_pc    <= '0;
    end else begin
      inflight_q       <= issue;
      o_fetch_misalign <= misalign;
      if (misalign) o_misalign_pc <= i_redirect_pc;
      if (i_redirect_valid) pc_q <= {i_redirect_pc[31:2], 2'b00};
      else if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= o_imem_addr;
      end
    end
  end
  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ret),
    .pop       (pop),
    .flush     (i_redirect_valid),
    .count     (count),
    .head      (head)
  );
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector table, corner sequences and randomized run against a queue model
module tb_fetch_pc_gen;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] o_imem_addr, i_imem_data, i_redirect_pc, o_inst, o_inst_pc, o_misalign_pc;
  logic i_redirect_valid = 1'b0, i_inst_ready = 1'b1;
  logic o_inst_valid, o_fetch_misalign;
  int checks = 0, errors = 0;
  logic [31:0] mq[$];
  bit m_infl = 0, m_mis = 0;
  logic [31:0] m_infl_pc = '0, m_pc = RESET_PC, m_mpc = '0;
  typedef struct {
    bit r;
    bit rv;
    logic [31:0] rpc;
    bit rdy;
    bit ev;
    logic [31:0] epc;
  } vec_t;
  vec_t vt[19];

  fetch_pc_gen #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_addr      (o_imem_addr),
    .i_imem_data      (i_imem_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_inst_valid     (o_inst_valid),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .i_inst_ready     (i_inst_ready),
    .o_fetch_misalign (o_fetch_misalign),
    .o_misalign_pc    (o_misalign_pc)
  );

  always #5 clk = ~clk;
  // memory returns word = address, one cycle after the address is presented
  always @(posedge clk) i_imem_data <= o_imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst = r;
    i_redirect_valid = rv;
    i_redirect_pc = rpc;
    i_inst_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_head(input string name, input bit v, input logic [31:0] pc);
    chk({name, " valid"}, 32'(o_inst_valid), 32'(v));
    if (v) begin
      chk({name, " pc"}, o_inst_pc, pc);
      chk({name, " inst"}, o_inst, pc);
    end
  endtask

  // reference: outstanding fetches = queued + in memory pipe, never more than DEPTH
  initial forever begin
    bit pop;
    int outstanding;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_infl = 0;
      m_pc = RESET_PC;
      m_mis = 0;
      m_mpc = '0;
    end else if (i_redirect_valid) begin
      mq.delete();
      m_infl = 0;
      m_pc = i_redirect_pc & ~32'd3;
      m_mis = i_redirect_pc[1:0] != 2'b00;
      if (m_mis) m_mpc = i_redirect_pc;
    end else begin
      pop = mq.size() > 0 && i_inst_ready;
      outstanding = mq.size() + int'(m_infl) - int'(pop);
      m_mis = 0;
      if (pop) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_infl_pc);
      if (outstanding < DEPTH) begin
        m_infl = 1;
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end else m_infl = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model valid", 32'(o_inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("model pc", o_inst_pc, mq[0]);
      chk("model inst", o_inst, mq[0]);
    end
    chk("model addr", o_imem_addr, m_pc);
    chk("model misalign", 32'(o_fetch_misalign), 32'(m_mis));
    chk("model misalign_pc", o_misalign_pc, m_mpc);
  end

  initial begin
    vt = '{
      '{1, 0, 32'h0, 1, 0, 32'h0}, '{1, 0, 32'h0, 1, 0, 32'h0},
      '{0, 0, 32'h0, 1, 0, 32'h0}, '{0, 0, 32'h0, 1, 1, 32'h0},
      '{0, 0, 32'h0, 1, 1, 32'h4}, '{0, 0, 32'h0, 1, 1, 32'h8},
      '{0, 0, 32'h0, 0, 1, 32'h8}, '{0, 0, 32'h0, 0, 1, 32'h8},
      '{0, 0, 32'h0, 0, 1, 32'h8}, '{0, 0, 32'h0, 0, 1, 32'h8},
      '{0, 0, 32'h0, 0, 1, 32'h8}, '{0, 0, 32'h0, 1, 1, 32'hC},
      '{0, 0, 32'h0, 1, 1, 32'h10}, '{0, 0, 32'h0, 1, 1, 32'h14},
      '{0, 1, 32'h100, 0, 0, 32'h0}, '{0, 0, 32'h0, 1, 0, 32'h0},
      '{0, 0, 32'h0, 1, 1, 32'h100}, '{0, 0, 32'h0, 1, 1, 32'h104},
      '{0, 0, 32'h0, 1, 1, 32'h108}
    };
    @(negedge clk);
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].rv, vt[i].rpc, vt[i].rdy);
      expect_head($sformatf("vec%0d", i), vt[i].ev, vt[i].epc);
      if (vt[i].r) chk($sformatf("vec%0d addr", i), o_imem_addr, RESET_PC);
    end
    step(0, 1, 32'h300, 1);
    expect_head("redir_pop t1", 0, 0);
    step(0, 0, 0, 1);
    expect_head("redir_pop t2", 0, 0);
    step(0, 0, 0, 1);
    expect_head("redir_pop t3", 1, 32'h300);
    step(0, 0, 0, 1);
    expect_head("redir_pop t4", 1, 32'h304);
    step(0, 1, 32'h202, 1);
    chk("misalign pulse", 32'(o_fetch_misalign), 1);
    chk("misalign pc", o_misalign_pc, 32'h202);
    expect_head("misalign t1", 0, 0);
    step(0, 0, 0, 1);
    chk("misalign end", 32'(o_fetch_misalign), 0);
    chk("misalign hold", o_misalign_pc, 32'h202);
    step(0, 0, 0, 1);
    expect_head("misalign t3", 1, 32'h200);
    step(0, 0, 0, 1);
    expect_head("misalign t4", 1, 32'h204);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    expect_head("wrap top", 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    expect_head("wrap zero", 1, 32'h0);
    step(1, 0, 0, 1);
    expect_head("midrst", 0, 0);
    chk("midrst inst", o_inst, 0);
    chk("midrst inst_pc", o_inst_pc, 0);
    chk("midrst misalign_pc", o_misalign_pc, 0);
    chk("midrst addr", o_imem_addr, RESET_PC);
    step(0, 0, 0, 1);
    expect_head("restart t1", 0, 0);
    step(0, 0, 0, 1);
    expect_head("restart t2", 1, RESET_PC);
    step(0, 0, 0, 1);
    expect_head("restart t3", 1, RESET_PC + 32'd4);
    for (int n = 0; n < 3000; n++) begin
      bit r, rv, rdy;
      logic [31:0] t;
      r = $urandom_range(99) == 0;
      rv = !r && $urandom_range(19) == 0;
      rdy = $urandom_range(9) < 7;
      t = $urandom;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step(r, rv, t, rdy);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
